// File: rtl/decoder_arbiter_if.sv
// Codeword request / result bus between two producers, the decode engine and one consumer.
interface decoder_arbiter_if;
   logic        req0_valid;
   logic [11:0] req0_cx;
   logic        req0_ready;
   logic        req1_valid;
   logic [11:0] req1_cx;
   logic        req1_ready;
   logic        out_valid;
   logic [6:0]  out_data;
   logic        out_id;
   logic [1:0]  out_status;
   logic        out_ready;

   // Producer/consumer side
   modport master (
      output req0_valid, req0_cx, req1_valid, req1_cx, out_ready,
      input  req0_ready, req1_ready, out_valid, out_data, out_id, out_status
   );

   // Decode engine side
   modport slave (
      input  req0_valid, req0_cx, req1_valid, req1_cx, out_ready,
      output req0_ready, req1_ready, out_valid, out_data, out_id, out_status
   );
endinterface

// File: rtl/decoder_arbiter.sv
// Two-port round-robin arbiter feeding a two-stage 12-bit codeword decoder,
// with saturating corrected/uncorrectable result counters.
module decoder_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   decoder_arbiter_if.slave   bus,
   input  logic               cnt_clear,
   output logic [CNT_W-1:0]   cnt_corr,
   output logic [CNT_W-1:0]   cnt_uncorr
);

   typedef enum logic [1:0] {
      ST_CLEAN   = 2'b00,
      ST_CORR    = 2'b01,
      ST_UNCORR  = 2'b10
   } status_e;

   logic              prio_q, prio_d;
   logic              s1_valid_q, s1_valid_d;
   logic [11:0]       s1_cx_q, s1_cx_d;
   logic              s1_id_q, s1_id_d;
   logic              out_valid_q, out_valid_d;
   logic [6:0]        out_data_q, out_data_d;
   logic              out_id_q, out_id_d;
   status_e           out_status_q, out_status_d;
   logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
   logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

   logic              gnt_vld, gnt_id;
   logic              s2_adv, s1_can_load, accept, out_hs;
   logic [4:0]        syn;
   logic [6:0]        flip_mask;
   logic [6:0]        dec_data;
   status_e           dec_status;

   assign s2_adv      = !out_valid_q || bus.out_ready;
   assign s1_can_load = !s1_valid_q || s2_adv;
   assign accept      = gnt_vld && s1_can_load && !rst;
   assign out_hs      = out_valid_q && bus.out_ready;

   // Round-robin grant: a lone requester always wins, contention goes to prio
   always_comb begin
      gnt_vld = bus.req0_valid || bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) gnt_id = prio_q;
      else                                  gnt_id = bus.req1_valid;
   end

   // Syndrome and correction of the stage-1 codeword
   always_comb begin
      syn[0] = ^{s1_cx_q[0], s1_cx_q[1], s1_cx_q[5], s1_cx_q[6], s1_cx_q[7]};
      syn[1] = ^{s1_cx_q[0], s1_cx_q[2], s1_cx_q[4], s1_cx_q[5], s1_cx_q[8]};
      syn[2] = ^{s1_cx_q[0], s1_cx_q[1], s1_cx_q[3], s1_cx_q[5], s1_cx_q[6], s1_cx_q[9]};
      syn[3] = ^{s1_cx_q[0], s1_cx_q[1], s1_cx_q[3], s1_cx_q[5], s1_cx_q[6], s1_cx_q[10]};
      syn[4] = ^{s1_cx_q[1], s1_cx_q[3], s1_cx_q[5], s1_cx_q[6], s1_cx_q[11]};
      flip_mask  = '0;
      dec_status = ST_UNCORR;
      case (syn)
         5'b00000: dec_status = ST_CLEAN;
         5'b01111: begin dec_status = ST_CORR; flip_mask = 7'b000_0001; end
         5'b11100: begin dec_status = ST_CORR; flip_mask = 7'b000_1000; end
         5'b11111: begin dec_status = ST_CORR; flip_mask = 7'b010_0000; end
         // check-bit flips: status corrected, data untouched
         5'b00001, 5'b00100,
         5'b01000, 5'b10000: dec_status = ST_CORR;
         default:            dec_status = ST_UNCORR;
      endcase
      dec_data = s1_cx_q[6:0] ^ flip_mask;
   end

   // Next state for arbiter pointer, both pipeline stages and counters
   always_comb begin
      prio_d       = prio_q;
      s1_valid_d   = s1_valid_q;
      s1_cx_d      = s1_cx_q;
      s1_id_d      = s1_id_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_id_d     = out_id_q;
      out_status_d = out_status_q;
      cnt_corr_d   = cnt_corr_q;
      cnt_uncorr_d = cnt_uncorr_q;

      if (accept) begin
         prio_d     = ~gnt_id;
         s1_valid_d = 1'b1;
         s1_cx_d    = gnt_id ? bus.req1_cx : bus.req0_cx;
         s1_id_d    = gnt_id;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d   = dec_data;
            out_id_d     = s1_id_q;
            out_status_d = dec_status;
         end
      end

      if (cnt_clear) begin
         cnt_corr_d   = '0;
         cnt_uncorr_d = '0;
      end else if (out_hs) begin
         if (out_status_q == ST_CORR && cnt_corr_q != '1)
            cnt_corr_d = cnt_corr_q + CNT_W'(1);
         if (out_status_q == ST_UNCORR && cnt_uncorr_q != '1)
            cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q       <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_cx_q      <= '0;
         s1_id_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_id_q     <= 1'b0;
         out_status_q <= ST_CLEAN;
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else begin
         prio_q       <= prio_d;
         s1_valid_q   <= s1_valid_d;
         s1_cx_q      <= s1_cx_d;
         s1_id_q      <= s1_id_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_id_q     <= out_id_d;
         out_status_q <= out_status_d;
         cnt_corr_q   <= cnt_corr_d;
         cnt_uncorr_q <= cnt_uncorr_d;
      end
   end

   assign bus.req0_ready = accept && !gnt_id;
   assign bus.req1_ready = accept &&  gnt_id;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_id     = out_id_q;
   assign bus.out_status = out_status_q;
   assign cnt_corr       = cnt_corr_q;
   assign cnt_uncorr     = cnt_uncorr_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Randomized bench for decoder_arbiter against a transaction-level reference model.
module tb_decoder_arbiter;

   localparam int unsigned CW  = 4;
   localparam int          SAT = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           cnt_clear;
   logic [CW-1:0]  cnt_corr, cnt_uncorr;

   decoder_arbiter_if bus();

   decoder_arbiter #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cnt_clear  (cnt_clear),
      .cnt_corr   (cnt_corr),
      .cnt_uncorr (cnt_uncorr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Parity-check column for each codeword bit, read off the syndrome equations
   function automatic logic [4:0] hcol(input int unsigned i);
      case (i)
         0:  return 5'b01111;
         1:  return 5'b11101;
         2:  return 5'b00010;
         3:  return 5'b11100;
         4:  return 5'b00010;
         5:  return 5'b11111;
         6:  return 5'b11101;
         7:  return 5'b00001;
         8:  return 5'b00010;
         9:  return 5'b00100;
         10: return 5'b01000;
         default: return 5'b10000;
      endcase
   endfunction

   function automatic logic [4:0] msyn(input logic [11:0] cx);
      logic [4:0] s;
      s = '0;
      for (int unsigned i = 0; i < 12; i++) if (cx[i]) s ^= hcol(i);
      return s;
   endfunction

   // A syndrome is correctable only if exactly one bit position produces it
   function automatic void mdecode(input logic [11:0] cx, output logic [6:0] d, output logic [1:0] st);
      logic [4:0] s;
      int hits, pos;
      s = msyn(cx);
      d = cx[6:0];
      hits = 0;
      pos = 0;
      if (s == 5'b0) begin
         st = 2'b00;
      end else begin
         for (int i = 0; i < 12; i++) if (hcol(i) == s) begin hits++; pos = i; end
         if (hits == 1) begin
            st = 2'b01;
            if (pos < 7) d[pos] = ~d[pos];
         end else begin
            st = 2'b10;
         end
      end
   endfunction

   function automatic logic [11:0] enc(input logic [6:0] d);
      return {msyn({5'b0, d}), d};
   endfunction

   function automatic logic [11:0] gen_cx();
      logic [11:0] c;
      c = enc(7'($urandom));
      case ($urandom_range(3))
         0: ;
         1: c[$urandom_range(11)] ^= 1'b1;
         2: begin c[$urandom_range(11)] ^= 1'b1; c[$urandom_range(11)] ^= 1'b1; end
         default: c = 12'($urandom);
      endcase
      return c;
   endfunction

   typedef struct {
      logic [11:0] cx;
      logic        id;
      int          acc_e;
   } item_t;

   item_t q[$];
   int    e      = 0;
   logic  m_prio = 1'b0;
   int    m_corr = 0;
   int    m_uncorr = 0;

   // One clock cycle: drive, check against the model, advance the model across the edge
   task automatic step(input logic v0, input logic [11:0] c0, input logic v1, input logic [11:0] c1,
                       input logic ordy, input logic clr, input logic r);
      int n;
      logic ov_exp, g, acc, hs;
      logic [6:0] d;
      logic [1:0] st;
      item_t it;
      bus.req0_valid = v0;
      bus.req0_cx    = c0;
      bus.req1_valid = v1;
      bus.req1_cx    = c1;
      bus.out_ready  = ordy;
      cnt_clear      = clr;
      rst            = r;
      #2;
      n = q.size();
      // Two in flight means the older one is in the output stage; a lone one needs one edge to get there
      ov_exp = (n >= 2) || (n == 1 && e >= q[0].acc_e + 1);
      check("out_valid", bus.out_valid, ov_exp);
      if (ov_exp) begin
         mdecode(q[0].cx, d, st);
         check("out_data", bus.out_data, d);
         check("out_status", bus.out_status, st);
         check("out_id", bus.out_id, q[0].id);
      end
      check("cnt_corr", cnt_corr, m_corr);
      check("cnt_uncorr", cnt_uncorr, m_uncorr);
      g   = (v0 && v1) ? m_prio : v1;
      acc = !r && (v0 || v1) && (n < 2 || ordy);
      check("req0_ready", bus.req0_ready, acc && !g);
      check("req1_ready", bus.req1_ready, acc && g);
      hs = ov_exp && ordy;

      @(posedge clk);
      e++;
      if (r) begin
         q.delete();
         m_prio   = 1'b0;
         m_corr   = 0;
         m_uncorr = 0;
      end else begin
         st = 2'b00;
         if (hs) begin
            mdecode(q[0].cx, d, st);
            void'(q.pop_front());
         end
         if (clr) begin
            m_corr   = 0;
            m_uncorr = 0;
         end else if (hs) begin
            if (st == 2'b01 && m_corr < SAT)   m_corr++;
            if (st == 2'b10 && m_uncorr < SAT) m_uncorr++;
         end
         if (acc) begin
            it.cx    = g ? c1 : c0;
            it.id    = g;
            it.acc_e = e;
            q.push_back(it);
            m_prio = ~g;
         end
      end
      #1;
   endtask

   logic [11:0] dir_cx [7];

   initial begin
      rst            = 1'b1;
      cnt_clear      = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_cx    = '0;
      bus.req1_valid = 1'b1;
      bus.req1_cx    = '0;
      bus.out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, 7'h00);
      check("rst_out_id", bus.out_id, 1'b0);
      check("rst_out_status", bus.out_status, 2'b00);
      check("rst_cnt_corr", cnt_corr, 0);
      check("rst_cnt_uncorr", cnt_uncorr, 0);
      check("rst_req0_ready", bus.req0_ready, 1'b0);
      check("rst_req1_ready", bus.req1_ready, 1'b0);

      // Single requester: clean, single-bit, ambiguous and double-error words
      dir_cx = '{12'h000, enc(7'h7F), 12'h001, 12'h080, 12'h020, 12'h004, 12'h003};
      foreach (dir_cx[i]) step(1'b1, dir_cx[i], 1'b0, '0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Contention with free-flowing output
      repeat (6) step(1'b1, gen_cx(), 1'b1, gen_cx(), 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Backpressure then drain
      repeat (5) step(1'b1, gen_cx(), 1'b1, gen_cx(), 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Saturate the corrected counter, then clear on a corrected handshake
      repeat (SAT + 3) step(1'b0, '0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of traffic
      repeat (3) step(1'b1, 12'h001, 1'b1, 12'h003, 1'b1, 1'b0, 1'b0);
      step(1'b1, 12'h001, 1'b1, 12'h003, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(9) < 7, gen_cx(), $urandom_range(9) < 7, gen_cx(),
              $urandom_range(3) != 0, $urandom_range(49) == 0, $urandom_range(99) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
